led_pwm_ctrl: RTL and testbench

//  Parametrised multi-channel LED driver; successor to the single-LED heartbeat blinker.

---
 rtl/led_pwm_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 28 ++
 rtl/led_pwm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM driver: mode encodings and field widths.
package led_pwm_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_PWM     = 3'd2,
    LED_BLINK   = 3'd3,
    LED_BREATHE = 3'd4
  } led_mode_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..DIV-1 and pulses tick for one clk on the wrap cycle.
module led_tick_gen #(
  parameter int DIV = 390
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_r;

  assign tick = (div_cnt_r == LAST);

  // Prescale counter; with DIV=1 it stays at zero and tick is constantly high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (tick) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: per-channel off/on/PWM/blink/breathe, config double-buffered
// so mode and duty changes only take effect on a PWM frame boundary.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int  NUM_CH       = 6,
  parameter int  PWM_BITS     = 8,
  parameter int  TICK_DIV     = 390,
  parameter int  BLINK_HALF   = 500,
  parameter int  BREATHE_STEP = 2,
  localparam int CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                a_reset,
  input  logic                cfg_valid,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic                frame_start,
  output logic [NUM_CH-1:0]   led_out
);

  localparam int                  BLW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int                  SW         = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};
  localparam logic [BLW-1:0]      BLINK_LAST = BLW'(BLINK_HALF - 1);
  localparam logic [SW-1:0]       STEP_LAST  = SW'(BREATHE_STEP - 1);
  localparam logic [CW:0]         NUM_CH_V   = (CW + 1)'(NUM_CH);

  logic                tick_s;
  logic                frame_s;
  logic                step_s;
  logic                ch_ok_s;
  logic [NUM_CH-1:0]   lit_vec_s;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [BLW-1:0]      blink_cnt_r;
  logic                blink_on_r;
  logic [SW-1:0]       step_cnt_r;
  logic [PWM_BITS-1:0] breathe_lvl_r;
  logic                breathe_up_r;
  logic [NUM_CH-1:0]   led_out_r;
  logic                frame_start_r;
  logic                cfg_err_r;

  led_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (a_reset),
    .tick (tick_s)
  );

  assign frame_s = tick_s && (pwm_cnt_r == PWM_MAX);
  assign step_s  = frame_s && (step_cnt_r == STEP_LAST);
  assign ch_ok_s = ({1'b0, cfg_ch} < NUM_CH_V);

  // PWM position within the frame and the shared blink phase
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      pwm_cnt_r   <= '0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else begin
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      end
      if (frame_s) begin
        if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_r <= '0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLW'(1);
        end
      end
    end
  end

  // Shared breathe triangle; each endpoint is held for exactly one step before turning
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      step_cnt_r    <= '0;
      breathe_lvl_r <= '0;
      breathe_up_r  <= 1'b1;
    end else begin
      if (frame_s) begin
        step_cnt_r <= step_s ? '0 : step_cnt_r + SW'(1);
      end
      if (step_s) begin
        if (breathe_up_r) begin
          if (breathe_lvl_r == PWM_MAX) begin
            breathe_up_r  <= 1'b0;
            breathe_lvl_r <= breathe_lvl_r - PWM_BITS'(1);
          end else begin
            breathe_lvl_r <= breathe_lvl_r + PWM_BITS'(1);
          end
        end else if (breathe_lvl_r == '0) begin
          breathe_up_r  <= 1'b1;
          breathe_lvl_r <= breathe_lvl_r + PWM_BITS'(1);
        end else begin
          breathe_lvl_r <= breathe_lvl_r - PWM_BITS'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MODE_W-1:0]   shadow_mode_r;
    logic [MODE_W-1:0]   active_mode_r;
    logic [PWM_BITS-1:0] shadow_duty_r;
    logic [PWM_BITS-1:0] active_duty_r;
    logic                wr_s;
    logic                lit_s;

    assign wr_s         = cfg_valid && ch_ok_s && (cfg_ch == CW'(i));
    assign lit_vec_s[i] = lit_s;

    // A write landing on the boundary edge updates the shadow only, so it waits a frame
    always_ff @(posedge clk or posedge a_reset) begin
      if (a_reset) begin
        shadow_mode_r <= LED_OFF;
        shadow_duty_r <= '0;
        active_mode_r <= LED_OFF;
        active_duty_r <= '0;
      end else begin
        if (wr_s) begin
          shadow_mode_r <= cfg_mode;
          shadow_duty_r <= cfg_duty;
        end
        if (frame_s) begin
          active_mode_r <= shadow_mode_r;
          active_duty_r <= shadow_duty_r;
        end
      end
    end

    // Per-channel drive decision; reserved codes fall to dark
    always_comb begin
      lit_s = 1'b0;
      case (active_mode_r)
        LED_OFF:     lit_s = 1'b0;
        LED_ON:      lit_s = 1'b1;
        LED_PWM:     lit_s = (pwm_cnt_r < active_duty_r);
        LED_BLINK:   lit_s = blink_on_r && (pwm_cnt_r < active_duty_r);
        LED_BREATHE: lit_s = (pwm_cnt_r < breathe_lvl_r);
        default:     lit_s = 1'b0;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      led_out_r     <= '0;
      frame_start_r <= 1'b0;
      cfg_err_r     <= 1'b0;
    end else begin
      led_out_r     <= lit_vec_s;
      frame_start_r <= frame_s;
      cfg_err_r     <= cfg_valid && !ch_ok_s;
    end
  end

  assign led_out     = led_out_r;
  assign frame_start = frame_start_r;
  assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: reset timing, PWM duty, shadowing, blink, breathe, errors.
module tb_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       a_reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [2:0] cfg_mode = 3'd0;
  logic [2:0] cfg_duty = 3'd0;
  logic       cfg_err;
  logic       frame_start;
  logic [3:0] led_out;

  // second instance with 5 channels so that cfg_ch=5 is representable and out of range
  logic       e_valid = 1'b0;
  logic [2:0] e_ch = 3'd0;
  logic [2:0] e_mode = 3'd0;
  logic [2:0] e_duty = 3'd0;
  logic       e_err;
  logic       e_fs;
  logic [4:0] e_led;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_q[4];
  int waited;

  // clk counts per measured frame; frames 1..16 after reset
  int blink_tab[16]   = '{14, 0, 0, 14, 14, 0, 0, 14, 14, 0, 0, 14, 14, 0, 0, 14};
  int breathe_tab[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  always #5 clk = ~clk;

  led_pwm_ctrl #(
    .NUM_CH(4), .PWM_BITS(3), .TICK_DIV(2), .BLINK_HALF(2), .BREATHE_STEP(1)
  ) u_dut (
    .clk(clk), .a_reset(a_reset), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_err(cfg_err),
    .frame_start(frame_start), .led_out(led_out)
  );

  led_pwm_ctrl #(
    .NUM_CH(5), .PWM_BITS(3), .TICK_DIV(2), .BLINK_HALF(2), .BREATHE_STEP(1)
  ) u_dut_err (
    .clk(clk), .a_reset(a_reset), .cfg_valid(e_valid), .cfg_ch(e_ch),
    .cfg_mode(e_mode), .cfg_duty(e_duty), .cfg_err(e_err),
    .frame_start(e_fs), .led_out(e_led)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    logic seen;
    seen = 1'b0;
    a_reset = 1'b1;
    cfg_valid = 1'b0;
    e_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen = seen | frame_start;
    end
    check_val("rst_led", 32'(led_out), 32'd0);
    check_val("rst_fs_quiet", 32'(seen), 32'd0);
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    a_reset = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [2:0] mode, input logic [2:0] duty);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_mode = mode;
    cfg_duty = duty;
    @(negedge clk);
    cfg_valid = 1'b0;
    check_val("cfg_err_quiet", 32'(cfg_err), 32'd0);
  endtask

  task automatic wait_fs(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (frame_start) begin
        n = k;
        found = 1'b1;
        break;
      end
    end
    check_val("fs_seen", 32'(found), 32'd1);
  endtask

  task automatic measure();
    for (int c = 0; c < 4; c++) cnt_q[c] = 0;
    repeat (16) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) cnt_q[c] += int'(led_out[c]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    logic early;

    // reset hold and first frame_start timing
    reset_dut();
    wait_fs(waited);
    check_val("first_fs_delay", 32'(waited), 32'd16);
    wait_fs(waited);
    check_val("fs_period", 32'(waited), 32'd16);

    // PWM duty 3, 0, 7 on channel 0
    reset_dut();
    do_write(2'd0, 3'd2, 3'd3);
    wait_fs(waited);
    measure();
    check_val("pwm_duty3", 32'(cnt_q[0]), 32'd6);
    check_val("pwm_other_dark", 32'(cnt_q[1] + cnt_q[2] + cnt_q[3]), 32'd0);
    do_write(2'd0, 3'd2, 3'd0);
    wait_fs(waited);
    measure();
    check_val("pwm_duty0", 32'(cnt_q[0]), 32'd0);
    do_write(2'd0, 3'd2, 3'd7);
    wait_fs(waited);
    measure();
    check_val("pwm_duty7", 32'(cnt_q[0]), 32'd14);

    // shadowing: mid-frame write waits for the boundary
    reset_dut();
    repeat (6) @(negedge clk);
    do_write(2'd1, 3'd1, 3'd0);
    early = 1'b0;
    for (int k = 0; k < 40; k++) begin
      early = early | led_out[1];
      if (frame_start) break;
      @(negedge clk);
    end
    check_val("shadow_fs_reached", 32'(frame_start), 32'd1);
    check_val("shadow_early_dark", 32'(early), 32'd0);
    @(negedge clk);
    check_val("shadow_on_after_fs", 32'(led_out[1]), 32'd1);
    // write during the boundary cycle: missed by this load, taken by the next one
    repeat (14) @(negedge clk);
    do_write(2'd1, 3'd0, 3'd0);
    check_val("coincident_fs", 32'(frame_start), 32'd1);
    lit = 0;
    repeat (16) begin
      @(negedge clk);
      lit += int'(led_out[1]);
    end
    check_val("coincident_held_on", 32'(lit), 32'd16);
    @(negedge clk);
    check_val("coincident_off_later", 32'(led_out[1]), 32'd0);

    // blink on ch2 and breathe on ch3 over 16 frames
    reset_dut();
    do_write(2'd2, 3'd3, 3'd7);
    do_write(2'd3, 3'd4, 3'd0);
    wait_fs(waited);
    for (int f = 0; f < 16; f++) begin
      measure();
      check_val($sformatf("blink_f%0d", f + 1), 32'(cnt_q[2]), 32'(blink_tab[f]));
      check_val($sformatf("breathe_f%0d", f + 1), 32'(cnt_q[3]), 32'(2 * breathe_tab[f]));
    end

    // reserved mode, invalid channel, mid-frame reset
    reset_dut();
    do_write(2'd0, 3'd6, 3'd7);
    do_write(2'd1, 3'd1, 3'd0);
    e_valid = 1'b1;
    e_ch = 3'd5;
    e_mode = 3'd1;
    e_duty = 3'd7;
    @(negedge clk);
    e_valid = 1'b0;
    check_val("err_pulse", 32'(e_err), 32'd1);
    @(negedge clk);
    check_val("err_one_cycle", 32'(e_err), 32'd0);
    e_valid = 1'b1;
    e_ch = 3'd4;
    @(negedge clk);
    e_valid = 1'b0;
    check_val("err_valid_ch4", 32'(e_err), 32'd0);
    wait_fs(waited);
    measure();
    check_val("reserved_dark", 32'(cnt_q[0]), 32'd0);
    check_val("on_lit", 32'(cnt_q[1]), 32'd16);
    check_val("err_no_change", 32'(e_led), 32'b10000);
    repeat (5) @(negedge clk);
    check_val("pre_reset_lit", 32'(led_out[1]), 32'd1);
    a_reset = 1'b1;
    #1;
    check_val("async_clear", 32'(led_out), 32'd0);
    @(negedge clk);
    a_reset = 1'b0;
    wait_fs(waited);
    check_val("post_reset_fs", 32'(waited), 32'd16);
    measure();
    check_val("post_reset_all_off", 32'(cnt_q[0] + cnt_q[1] + cnt_q[2] + cnt_q[3]), 32'd0);
    check_val("post_reset_err_dut", 32'(e_led), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
